// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and constants for the four-channel burst arbiter.
package mux_sel_arbiter_pkg;

    localparam int NUM_CH            = 4;
    localparam int SEL_W             = $clog2(NUM_CH);
    localparam int BURST_LEN_DEFAULT = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/mux-control bundle between the channel side (master) and the arbiter (slave).
interface mux_sel_arbiter_if;
    import mux_sel_arbiter_pkg::*;

    logic [NUM_CH-1:0] req;
    logic              out_ready;
    logic [SEL_W-1:0]  sel;
    logic              out_valid;
    logic [NUM_CH-1:0] ack;
    logic              busy;

    modport master (
        output req,
        output out_ready,
        input  sel,
        input  out_valid,
        input  ack,
        input  busy
    );

    modport slave (
        input  req,
        input  out_ready,
        output sel,
        output out_valid,
        output ack,
        output busy
    );

endinterface

// File: rtl/mux_sel_arbiter_rr_pick4.sv
// Combinational round-robin pick: first requester after last_grant_i, wrapping mod 4.
module rr_pick4
    import mux_sel_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  last_grant_i,
    output logic [SEL_W-1:0]  grant_o,
    output logic              any_req_o
);

    logic [SEL_W-1:0] idx;

    // Scan from the farthest offset down so the nearest requester after last_grant_i wins.
    always_comb begin
        grant_o   = last_grant_i;
        any_req_o = |req_i;
        idx       = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = last_grant_i + SEL_W'(i);
            if (req_i[idx]) begin
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Four-channel mux-select arbiter: round-robin grant, bursts of up to BURST_LEN beats per tenure.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_sel_arbiter_if.slave  bus
);

    localparam int               CNT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  lastGrant_q, lastGrant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [SEL_W-1:0]  pickIdx;
    logic              anyReq;
    logic              outValid;
    logic              beat;
    logic [NUM_CH-1:0] ackVec;

    rr_pick4 uPick (
        .req_i        (bus.req),
        .last_grant_i (lastGrant_q),
        .grant_o      (pickIdx),
        .any_req_o    (anyReq)
    );

    // State, select, round-robin pointer and beat counter; reset leaves channel 0 first in line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            lastGrant_q <= '1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            lastGrant_q <= lastGrant_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next state: IDLE lasts one cycle when anyone asks; GRANT ends on a dropped request or the last beat.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        lastGrant_d = lastGrant_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    sel_d       = pickIdx;
                    lastGrant_d = pickIdx;
                    cnt_d       = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (!bus.req[sel_q]) begin
                    state_d = IDLE;
                end else if (beat) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: valid follows the granted request live, and is forced low while reset is held.
    always_comb begin
        outValid = 1'b0;
        ackVec   = '0;
        if (rst_n && (state_q == GRANT)) begin
            outValid = bus.req[sel_q];
        end
        beat = outValid && bus.out_ready;
        if (beat) begin
            ackVec[sel_q] = 1'b1;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.out_valid = outValid;
    assign bus.ack       = ackVec;
    assign bus.busy      = (state_q == GRANT);

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench: two arbiters (BURST_LEN 4 and 1) driven together against a tenure-level reference model.
module tb_mux_sel_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    mux_sel_arbiter_if bus0 ();
    mux_sel_arbiter_if bus1 ();

    mux_sel_arbiter #(.BURST_LEN(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    mux_sel_arbiter #(.BURST_LEN(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    int checkCount = 0;
    int failCount  = 0;

    // Tenure-level model state, one slot per DUT.
    int   burst [2] = '{4, 1};
    bit   inTenure [2];
    int   owner [2];
    int   beatsDone [2];
    int   lastOwner [2];
    bit   modelValid = 1'b0;

    // Observed outputs captured at the sample point of the most recent cycle.
    logic [1:0] selSeen [2];
    logic       validSeen [2];
    logic [3:0] ackSeen [2];
    logic       busySeen [2];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive at negedge, sample and compare just after, advance the model at posedge.
    task automatic applyStimulus(input logic [3:0] r, input logic rdy, input logic rn);
        logic       expValid;
        logic [3:0] expAck;
        int         cand;
        @(negedge clk);
        bus0.req       = r;
        bus1.req       = r;
        bus0.out_ready = rdy;
        bus1.out_ready = rdy;
        rst_n          = rn;
        #1;
        selSeen[0] = bus0.sel;  validSeen[0] = bus0.out_valid;
        ackSeen[0] = bus0.ack;  busySeen[0]  = bus0.busy;
        selSeen[1] = bus1.sel;  validSeen[1] = bus1.out_valid;
        ackSeen[1] = bus1.ack;  busySeen[1]  = bus1.busy;
        if (modelValid) begin
            for (int k = 0; k < 2; k++) begin
                expValid = rn && inTenure[k] && r[owner[k]];
                expAck   = (expValid && rdy) ? (4'b0001 << owner[k]) : 4'b0000;
                checkOutput($sformatf("dut%0d.sel", k),       32'(selSeen[k]),   32'(owner[k] % 4));
                checkOutput($sformatf("dut%0d.out_valid", k), 32'(validSeen[k]), 32'(expValid));
                checkOutput($sformatf("dut%0d.ack", k),       32'(ackSeen[k]),   32'(expAck));
                checkOutput($sformatf("dut%0d.busy", k),      32'(busySeen[k]),  32'(inTenure[k]));
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rn) begin
                inTenure[k]  = 1'b0;
                owner[k]     = 0;
                lastOwner[k] = 3;
                beatsDone[k] = 0;
            end else if (!inTenure[k]) begin
                for (int step = 1; step <= 4; step++) begin
                    cand = (lastOwner[k] + step) % 4;
                    if (r[cand] && !inTenure[k]) begin
                        owner[k]     = cand;
                        lastOwner[k] = cand;
                        beatsDone[k] = 0;
                        inTenure[k]  = 1'b1;
                    end
                end
            end else if (!r[owner[k]]) begin
                inTenure[k] = 1'b0;
            end else if (rdy) begin
                beatsDone[k]++;
                if (beatsDone[k] == burst[k]) begin
                    inTenure[k] = 1'b0;
                end
            end
        end
        modelValid = 1'b1;
    endtask

    int   expA [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int   expB [6]  = '{0, 2, 0, 4, 0, 2};
    logic [3:0] rnd;

    initial begin
        $display("[TB] start");

        // Continuous single requester: four beats, one bubble, repeat.
        applyStimulus(4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(4'b0001, 1'b1, 1'b1);
            checkOutput($sformatf("single.ack[%0d]", i), 32'(ackSeen[0]), 32'(expA[i]));
        end

        // BURST_LEN=1 alternates between channels 1 and 2 with a bubble each time.
        applyStimulus(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b0110, 1'b1, 1'b1);
            checkOutput($sformatf("b1.ack[%0d]", i), 32'(ackSeen[1]), 32'(expB[i]));
        end

        // Channel 2 stalled by downstream for five cycles.
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0100, 1'b0, 1'b1);
            checkOutput("stall.valid", 32'(validSeen[0]), 32'd1);
            checkOutput("stall.ack",   32'(ackSeen[0]),   32'd0);
            checkOutput("stall.sel",   32'(selSeen[0]),   32'd2);
        end

        // Reset in the middle of a channel 3 tenure; channel 0 goes first afterwards.
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b1000, 1'b1, 1'b1);
        applyStimulus(4'b1000, 1'b1, 1'b1);
        applyStimulus(4'b1000, 1'b1, 1'b1);
        applyStimulus(4'b1000, 1'b1, 1'b0);
        checkOutput("rstmid.ack", 32'(ackSeen[0]), 32'd0);
        applyStimulus(4'b1001, 1'b1, 1'b1);
        checkOutput("rstmid.sel",  32'(selSeen[0]),  32'd0);
        checkOutput("rstmid.busy", 32'(busySeen[0]), 32'd0);
        applyStimulus(4'b1001, 1'b1, 1'b1);
        checkOutput("rstmid.ack0", 32'(ackSeen[0]), 32'd1);

        // Randomised traffic: sticky requests, mostly-ready downstream, rare resets.
        rnd = 4'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rnd = 4'($urandom);
            end
            applyStimulus(rnd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
